// File: rtl/riscv_defs.sv
// Shared RV32I typedefs and constants for the multi-cycle control unit.
package riscv_defs;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
    localparam logic [6:0] OPCODE_RR     = 7'b0110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_SRC1_ZERO = 2'd0;
    localparam logic [1:0] ALU_SRC1_RS1  = 2'd1;
    localparam logic [1:0] ALU_SRC1_PC   = 2'd2;

    localparam logic ALU_SRC2_RS2 = 1'b0;
    localparam logic ALU_SRC2_IMM = 1'b1;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SRC_IMM   = 2'b01;
    localparam logic [1:0] PC_SRC_JALR  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_src1;
        logic       alu_src2;
        logic [2:0] alu_op;
        logic       arith_logic;
        logic [1:0] wb_sel;
        logic [4:0] rd;
        logic       rf_wr;
        logic       dmem_rd;
        logic       dmem_wr;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
    } control_bus_t;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StTrap    = 3'd5
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I opcode-to-control-bus mapping; unknown words decode as a NOP.
module instr_decoder
    import riscv_defs::*;
(
    input  logic [31:0]  instruction,
    output control_bus_t bus,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [4:0] rd_field;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs2_field;
    logic       rd_nonzero;

    assign opcode     = instruction[6:0];
    assign rd_field   = instruction[11:7];
    assign funct3     = instruction[14:12];
    assign rs2_field  = instruction[24:20];
    assign funct7     = instruction[31:25];
    assign rd_nonzero = (rd_field != 5'd0);

    always_comb begin
        bus     = '0;
        illegal = 1'b0;
        case (opcode)
            OPCODE_LUI: begin
                bus.alu_src1 = ALU_SRC1_ZERO;
                bus.alu_src2 = ALU_SRC2_IMM;
                bus.rd       = rd_field;
                bus.rf_wr    = rd_nonzero;
            end
            OPCODE_AUIPC: begin
                bus.alu_src1 = ALU_SRC1_PC;
                bus.alu_src2 = ALU_SRC2_IMM;
                bus.rd       = rd_field;
                bus.rf_wr    = rd_nonzero;
            end
            OPCODE_JAL: begin
                bus.alu_src1 = ALU_SRC1_PC;
                bus.alu_src2 = ALU_SRC2_IMM;
                bus.wb_sel   = WB_SEL_PC4;
                bus.rd       = rd_field;
                bus.rf_wr    = rd_nonzero;
                bus.is_jal   = 1'b1;
            end
            OPCODE_JALR: begin
                bus.alu_src1 = ALU_SRC1_RS1;
                bus.alu_src2 = ALU_SRC2_IMM;
                bus.wb_sel   = WB_SEL_PC4;
                bus.rd       = rd_field;
                bus.rf_wr    = rd_nonzero;
                bus.is_jalr  = 1'b1;
            end
            OPCODE_BRANCH: begin
                bus.alu_src1  = ALU_SRC1_RS1;
                bus.alu_src2  = ALU_SRC2_RS2;
                bus.alu_op    = funct3;
                bus.is_branch = 1'b1;
            end
            OPCODE_LOAD: begin
                bus.alu_src1 = ALU_SRC1_RS1;
                bus.alu_src2 = ALU_SRC2_IMM;
                bus.wb_sel   = WB_SEL_MEM;
                bus.rd       = rd_field;
                bus.rf_wr    = rd_nonzero;
                bus.dmem_rd  = 1'b1;
            end
            OPCODE_STORE: begin
                // The rd slot forwards rs2 so the datapath can read the store data.
                bus.alu_src1 = ALU_SRC1_RS1;
                bus.alu_src2 = ALU_SRC2_IMM;
                bus.rd       = rs2_field;
                bus.dmem_wr  = 1'b1;
            end
            OPCODE_IMM: begin
                bus.alu_src1    = ALU_SRC1_RS1;
                bus.alu_src2    = ALU_SRC2_IMM;
                bus.alu_op      = funct3;
                bus.arith_logic = |funct7;
                bus.rd          = rd_field;
                bus.rf_wr       = rd_nonzero;
            end
            OPCODE_RR: begin
                bus.alu_src1    = ALU_SRC1_RS1;
                bus.alu_src2    = ALU_SRC2_RS2;
                bus.alu_op      = funct3;
                bus.arith_logic = |funct7;
                bus.rd          = rd_field;
                bus.rf_wr       = rd_nonzero;
            end
            OPCODE_FENCE, OPCODE_SYSTEM: begin
                bus = '0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/mem/writeback FSM with retire counter.
// Optional RV32_ILLEGAL_TRAP_EN sends illegal words to a terminal TRAP state.
module multicycle_control_unit
    import riscv_defs::*;
#(
    parameter int unsigned NB_WORD    = 32,
    parameter int unsigned NB_INSTRET = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [NB_WORD-1:0]    i_instruction,
    output logic                  o_imem_req,
    input  logic                  i_imem_ack,
    output logic                  o_dmem_req,
    input  logic                  i_dmem_ack,
    input  logic                  i_branch_taken,
    output logic                  o_ir_wr,
    output logic                  o_pc_wr,
    output logic [1:0]            o_pc_src,
    output control_bus_t          o_control_bus,
    output logic                  o_retire,
    output logic [NB_INSTRET-1:0] o_instret,
    output logic [2:0]            o_state
);

    state_t                  state_q;
    logic [NB_WORD-1:0]      ir_q;
    control_bus_t            bus_q;
    control_bus_t            dec_bus;
    logic                    dec_illegal;
    logic [NB_INSTRET-1:0]   instret_q;

    instr_decoder u_instr_decoder (
        .instruction (ir_q[31:0]),
        .bus         (dec_bus),
        .illegal     (dec_illegal)
    );

`ifndef RV32_ILLEGAL_TRAP_EN
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StFetch;
            ir_q    <= '0;
            bus_q   <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (i_imem_ack) begin
                        ir_q    <= i_instruction;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    bus_q <= dec_bus;
`ifdef RV32_ILLEGAL_TRAP_EN
                    state_q <= dec_illegal ? StTrap : StExecute;
`else
                    state_q <= StExecute;
`endif
                end
                StExecute: begin
                    if (bus_q.is_branch) begin
                        state_q <= StFetch;
                    end else if (bus_q.dmem_rd || bus_q.dmem_wr) begin
                        state_q <= StMem;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    if (i_dmem_ack) begin
                        state_q <= bus_q.dmem_wr ? StFetch : StWb;
                    end
                end
                StWb:    state_q <= StFetch;
                StTrap:  state_q <= StTrap;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Strobes decode from the registered state; gating with the reset drops any request at once.
    always_comb begin
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_ir_wr    = 1'b0;
        o_pc_wr    = 1'b0;
        o_pc_src   = PC_SRC_PLUS4;
        if (i_reset_n) begin
            unique case (state_q)
                StFetch: begin
                    o_imem_req = 1'b1;
                    o_ir_wr    = i_imem_ack;
                end
                StExecute: begin
                    if (bus_q.is_branch) begin
                        o_pc_wr  = 1'b1;
                        o_pc_src = i_branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                    end
                end
                StMem: begin
                    o_dmem_req = 1'b1;
                    o_pc_wr    = i_dmem_ack && bus_q.dmem_wr;
                end
                StWb: begin
                    o_pc_wr = 1'b1;
                    if (bus_q.is_jal) begin
                        o_pc_src = PC_SRC_IMM;
                    end else if (bus_q.is_jalr) begin
                        o_pc_src = PC_SRC_JALR;
                    end else begin
                        o_pc_src = PC_SRC_PLUS4;
                    end
                end
                default: begin
                    o_pc_wr = 1'b0;
                end
            endcase
        end
    end

    // Every PC update is the last action of an instruction.
    assign o_retire = o_pc_wr;

    always_comb begin
        o_control_bus         = bus_q;
        o_control_bus.rf_wr   = bus_q.rf_wr && (state_q == StWb);
        o_control_bus.dmem_rd = bus_q.dmem_rd && (state_q == StMem);
        o_control_bus.dmem_wr = bus_q.dmem_wr && (state_q == StMem);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            instret_q <= '0;
        end else if (o_retire) begin
            instret_q <= instret_q + NB_INSTRET'(1);
        end
    end

    assign o_instret = instret_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table plus reset/trap sequences.
module tb_multicycle_control_unit;
    import riscv_defs::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  instruction;
    logic         imem_req;
    logic         imem_ack;
    logic         dmem_req;
    logic         dmem_ack;
    logic         branch_taken;
    logic         ir_wr;
    logic         pc_wr;
    logic [1:0]   pc_src;
    control_bus_t cbus;
    logic         retire;
    logic [31:0]  instret;
    logic [2:0]   state;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .NB_WORD    (32),
        .NB_INSTRET (32)
    ) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_instruction  (instruction),
        .o_imem_req     (imem_req),
        .i_imem_ack     (imem_ack),
        .o_dmem_req     (dmem_req),
        .i_dmem_ack     (dmem_ack),
        .i_branch_taken (branch_taken),
        .o_ir_wr        (ir_wr),
        .o_pc_wr        (pc_wr),
        .o_pc_src       (pc_src),
        .o_control_bus  (cbus),
        .o_retire       (retire),
        .o_instret      (instret),
        .o_state        (state)
    );

    typedef struct {
        logic [31:0] instr;
        int          iw;     // imem wait cycles before ack
        int          dw;     // dmem wait cycles before ack
        bit          taken;
        bit          stray;  // hold imem_ack high while imem_req is low
        int          cyc;
        int          rf;
        int          rd;
        int          wb;
        int          pcsrc;
        int          dreq;
        int          src1;
        int          br;
        int          mem;    // bit0 dmem_rd seen, bit1 dmem_wr seen
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   instret_model = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [31:0] instr, input int iw, input int dw, input bit taken,
                           input bit stray, input int cyc, input int rf, input int rd,
                           input int wb, input int pcsrc, input int dreq, input int src1,
                           input int br, input int mem);
        vec_t v;
        v.instr = instr; v.iw = iw; v.dw = dw; v.taken = taken; v.stray = stray;
        v.cyc = cyc; v.rf = rf; v.rd = rd; v.wb = wb; v.pcsrc = pcsrc; v.dreq = dreq;
        v.src1 = src1; v.br = br; v.mem = mem;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int cyc = 0, icnt = 0, dcnt = 0, irw = 0, mem = 0, rfseen = 0, brpc = 0;
        bit done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            imem_ack     = imem_req ? (icnt == v.iw) : v.stray;
            dmem_ack     = dmem_req && (dcnt == v.dw);
            instruction  = v.instr;
            branch_taken = v.taken;
            #1;
            cyc++;
            if (cyc == 1) chk("instret_next", int'(instret), instret_model);
            if (imem_req) icnt++;
            if (dmem_req) dcnt++;
            if (ir_wr) begin
                irw++;
                sb.push_back(v);
            end
            if (cbus.rf_wr) rfseen = 1;
            if (cbus.dmem_rd) mem = mem | 1;
            if (cbus.dmem_wr) mem = mem | 2;
            if (pc_wr && state == 3'd2) brpc = 1;
            if (retire) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("cycles", cyc, e.cyc);
                    chk("rf_wr", rfseen, e.rf);
                    chk("rd", int'(cbus.rd), e.rd);
                    chk("wb_sel", int'(cbus.wb_sel), e.wb);
                    chk("pc_src", int'(pc_src), e.pcsrc);
                    chk("dmem_req_cycles", dcnt, e.dreq);
                    chk("alu_src1", int'(cbus.alu_src1), e.src1);
                    chk("pc_wr_execute", brpc, e.br);
                    chk("dmem_type", mem, e.mem);
                    chk("ir_wr_count", irw, 1);
                    chk("instret_at_retire", int'(instret), instret_model);
                end
                instret_model++;
            end
        end
        if (!done) begin
            chk("retire_timeout", cyc, -1);
            sb.delete();
        end
    endtask

    int n;
    int reqs;
    int rets;

    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; instruction = '0; branch_taken = 1'b0;

        //      instr         iw dw tk st cyc rf rd wb pcs drq src1 br mem
        add_vec(32'h002081B3, 0, 0, 0, 0, 4, 1, 3, 0, 0, 0, 1, 0, 0);  // add x3,x1,x2
        add_vec(32'h0000A103, 0, 3, 0, 0, 8, 1, 2, 1, 0, 4, 1, 0, 1);  // lw x2,0(x1)
        add_vec(32'h00208463, 0, 0, 1, 0, 3, 0, 0, 0, 1, 0, 1, 1, 0);  // beq taken
        add_vec(32'h00208463, 2, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0);  // beq not taken
        add_vec(32'h000080E7, 0, 0, 0, 0, 4, 1, 1, 2, 2, 0, 1, 0, 0);  // jalr x1
        add_vec(32'h00000013, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0);  // addi x0
        add_vec(32'h0020A023, 0, 1, 0, 1, 5, 0, 2, 0, 0, 2, 1, 0, 2);  // sw x2,0(x1)
        add_vec(32'h123450B7, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0);  // lui x1
        add_vec(32'h00001297, 0, 0, 0, 0, 4, 1, 5, 0, 0, 0, 2, 0, 0);  // auipc x5
        add_vec(32'h008000EF, 1, 0, 0, 0, 5, 1, 1, 2, 1, 0, 2, 0, 0);  // jal x1,8
`ifndef RV32_ILLEGAL_TRAP_EN
        add_vec(32'hFFFFFFFF, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);  // illegal -> NOP
`endif

        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_instret", int'(instret), 0);
        chk("reset_bus", int'(cbus), 0);
        chk("reset_imem_req", int'(imem_req), 0);
        chk("reset_dmem_req", int'(dmem_req), 0);
        chk("reset_ir_wr", int'(ir_wr), 0);
        chk("reset_pc_wr", int'(pc_wr), 0);
        chk("reset_retire", int'(retire), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("imem_req_after_reset", int'(imem_req), 1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset while a load waits for its data ack.
        instruction = 32'h0000A103;
        dmem_ack = 1'b0;
        n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            imem_ack = imem_req;
            #1;
            n++;
        end
        chk("mem_reached", int'(dmem_req), 1);
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_dmem_req", int'(dmem_req), 0);
        chk("midreset_state", int'(state), 0);
        chk("midreset_instret", int'(instret), 0);
        chk("midreset_retire", int'(retire), 0);
        @(negedge clk);
        rst_n = 1'b1;
        instret_model = 0;
        run_vec(vecs[0]);

`ifdef RV32_ILLEGAL_TRAP_EN
        instruction = 32'hFFFFFFFF;
        n = 0;
        while (!ir_wr && n < 20) begin
            @(negedge clk);
            imem_ack = imem_req;
            #1;
            n++;
        end
        chk("trap_fetch", int'(ir_wr), 1);
        reqs = 0;
        rets = 0;
        repeat (10) begin
            @(negedge clk);
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            #1;
            reqs += int'(imem_req) + int'(dmem_req);
            rets += int'(retire);
        end
        chk("trap_state", int'(state), 5);
        chk("trap_requests", reqs, 0);
        chk("trap_retires", rets, 0);
        chk("trap_instret", int'(instret), instret_model);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("trap_reset_state", int'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        instret_model = 0;
`endif

        @(negedge clk);
        #1;
        chk("instret_final", int'(instret), instret_model);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Multi-cycle RV32I sequencer.
- Replaces the single-cycle combinational decoder with an FSM that:
  - fetches an instruction through a request/acknowledge handshake,
  - decodes it into a registered control bus,
  - steps it through execute, memory and writeback.
- Sits between the instruction/data memory ports and the datapath (PC, IR, register file, ALU).
- Adds the sequencing the single-cycle decoder lacks: JAL, JALR, BRANCH, variable-latency memory, and retirement counting.

## Interface
Parameters:
- NB_WORD, 32, instruction/data word width.
- NB_INSTRET, 32, width of the retired-instruction counter.

Ports:
- i_clock  in  1  sole clock; all state updates on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_instruction  in  NB_WORD  fetched word; sampled only when i_imem_ack=1 in FETCH.
- o_imem_req  out  1  instruction fetch request.
- i_imem_ack  in  1  fetch complete.
- o_dmem_req  out  1  data access request.
- i_dmem_ack  in  1  data access complete.
- i_branch_taken  in  1  ALU comparison result; valid in EXECUTE.
- o_ir_wr  out  1  IR load strobe.
- o_pc_wr  out  1  PC update strobe.
- o_pc_src  out  2  next PC: 00 PC+4, 01 PC+imm (branch/JAL), 10 (rs1+imm)&~1 (JALR).
- o_control_bus  out  control_bus_t  registered decode fields; rf_wr/dmem_rd/dmem_wr are state-qualified.
- o_retire  out  1  one-cycle pulse per completed instruction.
- o_instret  out  NB_INSTRET  retired-instruction count.
- o_state  out  3  current FSM state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.
- **FETCH**
  - o_imem_req=1 until i_imem_ack.
  - On ack: o_ir_wr=1 and the word is latched, then go to DECODE.
- **DECODE**
  - Register all bus fields from the latched word.
  - LUI: alu_src1=zero, alu_src2=imm.
  - AUIPC: alu_src1=PC, alu_src2=imm.
  - JAL/JALR: wb_sel=PC+4.
  - LOAD: wb_sel=mem.
  - IMMEDIATE/R_R: alu_op=funct3, arith_logic=|funct7.
  - STORE: the rd field carries rs2.
  - FENCE/SYSTEM decode as a NOP.
  - Next state is EXECUTE.
- **EXECUTE**
  - BRANCH: o_pc_wr=1, o_pc_src=i_branch_taken?01:00, retire, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All other opcodes: go to WB.
- **MEM**
  - o_dmem_req=1 (dmem_rd or dmem_wr per type) until i_dmem_ack.
  - STORE on ack: o_pc_wr=1, src 00, retire, go to FETCH.
  - LOAD on ack: go to WB.
- **WB**
  - rf_wr=1 unless rd==0.
  - o_pc_wr=1 with src 01 for JAL, 10 for JALR, 00 otherwise.
  - Retire, go to FETCH.
- Handshake rules:
  - A request is held until its ack.
  - An ack while the request is low is ignored.
  - A request rises in the cycle the FSM enters its state.
- o_instret increments on each o_retire and wraps from 2^NB_INSTRET-1 to 0.

## Timing
- Reset (asynchronous, immediate):
  - State=FETCH, o_instret=0, control bus all zeros.
  - Every strobe, request and o_retire is 0.
  - o_imem_req asserts in the first cycle after i_reset_n deasserts.
- Reset mid-operation aborts any outstanding request combinationally; no partial retire is counted.
- Minimum latency with ack in the request's first cycle:
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle on an ack adds one cycle.
- o_retire coincides with the final o_pc_wr; o_instret shows the new value one cycle later.

## Configuration
- RV32_ILLEGAL_TRAP_EN
  - **Defined:** an unknown opcode, or instruction[1:0]!=2'b11, goes from DECODE to TRAP. TRAP is terminal until reset, holds every strobe and request low, and never retires. o_state=5.
  - **Undefined:** such words decode as a NOP and retire through the 4-cycle ALU path with rf_wr=0.

## Structure
- riscv_defs is the shared package for all typedefs and constants; it gains:
  - control_bus_t extensions: alu_src1 widened to 2 bits (zero/rs1/PC), wb_sel (2 bits: alu/mem/PC+4), is_branch, is_jal, is_jalr.
  - A state_t enum.
  - Opcode constants JAL, JALR, BRANCH, FENCE, SYSTEM.
  - PC_SRC_* encodings.
- Natural sub-module: instr_decoder, the combinational opcode-to-bus mapping.
- This block adds the FSM, bus register, handshakes and counter.

## Test plan
- R_R add (0x002081B3) with acks in the first cycle: 4 cycles; rf_wr in WB with rd=3; o_instret=1.
- Load (0x0000A103) with i_dmem_ack 3 cycles late: o_dmem_req held 4 cycles; total 8; wb_sel=mem.
- BEQ with i_branch_taken=1 then 0: o_pc_src=01 then 00; o_pc_wr in EXECUTE; no rf_wr.
- JALR x1 (0x000080E7): WB o_pc_src=10, wb_sel=PC+4; ADDI x0 (0x00000013): rf_wr stays 0 while o_retire still pulses.
- Word 0xFFFFFFFF:
  - With RV32_ILLEGAL_TRAP_EN: o_state=5, no further requests until i_reset_n low.
  - Without it: retires as a NOP.
- i_reset_n pulsed low during a MEM wait: o_dmem_req drops that cycle; state FETCH; o_instret=0.
